// File: rtl/dlx_decode_stage.sv
// DLX decode stage: instruction crack, register file with write bypass,
// pending-write scoreboard for RAW interlock, registered execute bundle.
module dlx_decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic              stall,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] imm,
  output logic [6:0]        cntrl_in,
  output logic              en_ex,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pend_nxt;

  logic [5:0]        opcode;
  logic              is_r;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] imm_d;
  logic [6:0]        cntrl_d;
  logic              hz1;
  logic              hz2;
  logic              hold;
  logic              fire;

  assign opcode = instr[31:26];
  assign is_r   = (opcode == 6'd0);
  assign rs1    = instr[25:21];
  assign rs2    = instr[20:16];
  assign rd     = is_r ? instr[15:11] : instr[20:16];

  // Register reads: r0 is hard zero, same-cycle write-back bypasses.
  always_comb begin
    rdata1 = regs[rs1];
    rdata2 = regs[rs2];
    if (wb_en && wb_addr == rs1) rdata1 = wb_data;
    if (wb_en && wb_addr == rs2) rdata2 = wb_data;
    if (rs1 == '0) rdata1 = '0;
    if (rs2 == '0) rdata2 = '0;
  end

  // Immediate and control word for the execute stage.
  always_comb begin
    imm_d   = '0;
    cntrl_d = {1'b0, instr[2:0], instr[5:3]};
    if (!is_r) begin
      cntrl_d = {1'b1, opcode[2:0], opcode[5:3]};
      if (opcode[5:3] == 3'b011)
        imm_d = {{(DATA_W-16){1'b0}}, instr[15:0]};
      else
        imm_d = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    end
  end

  // RAW interlock: a pending source blocks unless written back now.
  always_comb begin
    hz1 = pending[rs1] && (rs1 != '0) &&
          !(wb_en && wb_addr == rs1);
    hz2 = is_r && pending[rs2] && (rs2 != '0) &&
          !(wb_en && wb_addr == rs2);
  end

  assign hold        = en_ex && stall;
  assign instr_ready = !(hz1 || hz2) && !hold;
  assign fire        = instr_valid && instr_ready;

  // Scoreboard next state: clear on write-back, newer issue wins.
  always_comb begin
    pend_nxt = pending;
    if (wb_en) pend_nxt[wb_addr] = 1'b0;
    if (fire && rd != '0) pend_nxt[rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) pending <= '0;
    else      pending <= pend_nxt;
  end

  // Register file write port; r0 is never stored.
  always_ff @(posedge clk1) begin
    if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
  end

  // Execute bundle: hold on stall, load on transfer, else bubble.
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      src1     <= '0;
      src2     <= '0;
      imm      <= '0;
      cntrl_in <= '0;
      rd_addr  <= '0;
      en_ex    <= 1'b0;
    end else if (!hold) begin
      if (fire) begin
        src1     <= rdata1;
        src2     <= is_r ? rdata2 : '0;
        imm      <= imm_d;
        cntrl_in <= cntrl_d;
        rd_addr  <= rd;
        en_ex    <= 1'b1;
      end else begin
        en_ex    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dlx_decode_stage.sv
// Self-checking bench for dlx_decode_stage: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_dlx_decode_stage;

  logic        clk1 = 1'b0;
  logic        rst1 = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        stall = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] src1, src2, imm;
  logic [6:0]  cntrl_in;
  logic        en_ex;
  logic [4:0]  rd_addr;

  int total = 0;
  int bad = 0;

  dlx_decode_stage dut (
    .clk1(clk1), .rst1(rst1),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .src1(src1), .src2(src2), .imm(imm),
    .cntrl_in(cntrl_in), .en_ex(en_ex), .rd_addr(rd_addr)
  );

  always #5 clk1 = ~clk1;

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [31:0] rtype(
    input int a, input int b, input int d, input int fn);
    return {6'd0, 5'(a), 5'(b), 5'(d), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(
    input int opc, input int a, input int d, input int im);
    return {6'(opc), 5'(a), 5'(d), 16'(im)};
  endfunction

  task automatic test_reset;
    rst1 = 1'b1;
    tick; tick;
    total++; if (en_ex !== 1'b0) begin bad++; $display("FAIL rst_en got=%0h exp=0", en_ex); end
    total++; if (src1 !== 32'd0 || src2 !== 32'd0) begin bad++; $display("FAIL rst_src got=%0h/%0h exp=0", src1, src2); end
    total++; if (imm !== 32'd0 || cntrl_in !== 7'd0) begin bad++; $display("FAIL rst_imm got=%0h/%0h exp=0", imm, cntrl_in); end
    total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0h exp=0", rd_addr); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", instr_ready); end
    rst1 = 1'b0;
    tick;
  endtask

  task automatic test_rtype;
    wb_en = 1; wb_addr = 3; wb_data = 32'h10;
    tick;
    wb_en = 0;
    instr_valid = 1; instr = rtype(3, 0, 4, 6'b000001);
    tick;
    instr_valid = 0;
    total++; if (en_ex !== 1'b1) begin bad++; $display("FAIL t1_en got=%0h exp=1", en_ex); end
    total++; if (src1 !== 32'h10) begin bad++; $display("FAIL t1_src1 got=%0h exp=10", src1); end
    total++; if (src2 !== 32'h0) begin bad++; $display("FAIL t1_src2 got=%0h exp=0", src2); end
    total++; if (cntrl_in !== 7'b0_001_000) begin bad++; $display("FAIL t1_cntrl got=%b exp=0001000", cntrl_in); end
    total++; if (rd_addr !== 5'd4) begin bad++; $display("FAIL t1_rd got=%0d exp=4", rd_addr); end
    tick;
    total++; if (en_ex !== 1'b0) begin bad++; $display("FAIL t1_bubble got=%0h exp=0", en_ex); end
    wb_en = 1; wb_addr = 4; wb_data = 32'h44;
    tick;
    wb_en = 0;
  endtask

  task automatic test_back_to_back;
    instr_valid = 1; instr = itype(6'b001000, 3, 0, 16'hFFF0);
    tick;
    total++; if (imm !== 32'hFFFF_FFF0) begin bad++; $display("FAIL t2_sext got=%0h exp=fffffff0", imm); end
    total++; if (cntrl_in !== 7'b1_000_001) begin bad++; $display("FAIL t2_cntrl got=%b exp=1000001", cntrl_in); end
    total++; if (src2 !== 32'd0 || src1 !== 32'h10) begin bad++; $display("FAIL t2_src got=%0h/%0h exp=10/0", src1, src2); end
    instr = itype(6'b011000, 3, 0, 16'hFFF0);
    tick;
    instr_valid = 0;
    total++; if (en_ex !== 1'b1) begin bad++; $display("FAIL t2_b2b_en got=%0h exp=1", en_ex); end
    total++; if (imm !== 32'h0000_FFF0) begin bad++; $display("FAIL t2_zext got=%0h exp=0000fff0", imm); end
    total++; if (cntrl_in !== 7'b1_000_011) begin bad++; $display("FAIL t2_cntrl2 got=%b exp=1000011", cntrl_in); end
    tick;
  endtask

  task automatic test_hazard;
    instr_valid = 1; instr = rtype(0, 0, 5, 0);
    tick;
    total++; if (rd_addr !== 5'd5 || en_ex !== 1'b1) begin bad++; $display("FAIL t3_issue got=%0d/%0h exp=5/1", rd_addr, en_ex); end
    instr = rtype(5, 0, 6, 0);
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL t3_block got=%0h exp=0", instr_ready); end
    tick;
    total++; if (en_ex !== 1'b0) begin bad++; $display("FAIL t3_bubble got=%0h exp=0", en_ex); end
    wb_en = 1; wb_addr = 5; wb_data = 32'hABCD;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL t3_release got=%0h exp=1", instr_ready); end
    tick;
    wb_en = 0; instr_valid = 0;
    total++; if (en_ex !== 1'b1 || src1 !== 32'hABCD) begin bad++; $display("FAIL t3_bypass got=%0h/%0h exp=1/abcd", en_ex, src1); end
    wb_en = 1; wb_addr = 6; wb_data = 32'h66;
    tick;
    wb_en = 0;
  endtask

  task automatic test_stall;
    instr_valid = 1; instr = rtype(3, 0, 8, 6'b000011);
    tick;
    instr = rtype(3, 0, 9, 6'b010010);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL t4_ready%0d got=%0h exp=0", i, instr_ready); end
      tick;
      total++; if (en_ex !== 1'b1 || rd_addr !== 5'd8 || cntrl_in !== 7'b0_011_000) begin bad++; $display("FAIL t4_hold%0d got=%0h/%0d/%b exp=1/8/0011000", i, en_ex, rd_addr, cntrl_in); end
    end
    stall = 0;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL t4_unstall got=%0h exp=1", instr_ready); end
    tick;
    instr_valid = 0;
    total++; if (en_ex !== 1'b1 || rd_addr !== 5'd9 || cntrl_in !== 7'b0_010_010) begin bad++; $display("FAIL t4_next got=%0h/%0d/%b exp=1/9/0010010", en_ex, rd_addr, cntrl_in); end
    wb_en = 1; wb_addr = 8; wb_data = 32'h88;
    tick;
    wb_addr = 9; wb_data = 32'h99;
    tick;
    wb_en = 0;
  endtask

  task automatic test_set_wins;
    instr_valid = 1; instr = rtype(0, 0, 7, 0);
    wb_en = 1; wb_addr = 7; wb_data = 32'h77;
    tick;
    wb_en = 0;
    instr = rtype(7, 0, 0, 0);
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL t5_pending got=%0h exp=0", instr_ready); end
    tick;
    total++; if (en_ex !== 1'b0) begin bad++; $display("FAIL t5_bubble got=%0h exp=0", en_ex); end
    wb_en = 1; wb_addr = 7; wb_data = 32'h1234;
    tick;
    wb_en = 0; instr_valid = 0;
    total++; if (en_ex !== 1'b1 || src1 !== 32'h1234) begin bad++; $display("FAIL t5_read got=%0h/%0h exp=1/1234", en_ex, src1); end
    tick;
  endtask

  task automatic test_r0_reset;
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF;
    tick;
    wb_en = 0;
    instr_valid = 1; instr = rtype(0, 0, 10, 0);
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL t6_r0_ready got=%0h exp=1", instr_ready); end
    tick;
    total++; if (en_ex !== 1'b1 || src1 !== 32'd0) begin bad++; $display("FAIL t6_r0 got=%0h/%0h exp=1/0", en_ex, src1); end
    instr = rtype(10, 0, 0, 0); stall = 1;
    tick;
    rst1 = 1;
    #1;
    total++; if (en_ex !== 1'b0 || rd_addr !== 5'd0 || src1 !== 32'd0) begin bad++; $display("FAIL t6_rst got=%0h/%0d/%0h exp=0/0/0", en_ex, rd_addr, src1); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL t6_rst_ready got=%0h exp=1", instr_ready); end
    instr_valid = 0; stall = 0;
    #1;
    rst1 = 0;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] mreg [8];
    bit          mpend [8];
    bit          m_en;
    logic [31:0] m_src1, m_src2, m_imm;
    logic [6:0]  m_cntrl;
    int          m_rd;
    int          opc, a1, a2, d, fn;
    bit          isr, hz, ready_x, fire;
    for (int r = 1; r < 8; r++) begin
      wb_en = 1; wb_addr = 5'(r); wb_data = $urandom;
      mreg[r] = wb_data;
      tick;
    end
    wb_en = 0;
    mreg[0] = '0;
    for (int r = 0; r < 8; r++) mpend[r] = 0;
    m_en = 0; m_src1 = '0; m_src2 = '0; m_imm = '0; m_cntrl = '0; m_rd = 0;
    for (int c = 0; c < 400; c++) begin
      opc = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 63);
      a1 = $urandom_range(0, 7); a2 = $urandom_range(0, 7);
      d = $urandom_range(0, 7); fn = $urandom_range(0, 63);
      if (opc == 0) instr = rtype(a1, a2, d, fn);
      else instr = itype(opc, a1, a2, $urandom_range(0, 65535));
      instr_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      wb_en = ($urandom_range(0, 2) == 0);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;
      isr = (opc == 0);
      if (!isr) d = a2;
      hz = 0;
      if (a1 != 0 && mpend[a1] && !(wb_en && wb_addr == a1)) hz = 1;
      if (isr && a2 != 0 && mpend[a2] && !(wb_en && wb_addr == a2)) hz = 1;
      ready_x = !hz && !(m_en && stall);
      total++; if (instr_ready !== ready_x) begin bad++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, instr_ready, ready_x); end
      fire = instr_valid && ready_x;
      if (!(m_en && stall)) begin
        m_en = fire;
        if (fire) begin
          m_src1 = (a1 == 0) ? 0 : (wb_en && wb_addr == a1) ? wb_data : mreg[a1];
          m_src2 = (!isr || a2 == 0) ? 0 : (wb_en && wb_addr == a2) ? wb_data : mreg[a2];
          if (isr) begin
            m_imm = 0;
            m_cntrl = 7'((fn % 8) * 8 + fn / 8);
          end else begin
            if (opc / 8 == 3) m_imm = {16'd0, instr[15:0]};
            else m_imm = 32'($signed(instr[15:0]));
            m_cntrl = 7'(64 + (opc % 8) * 8 + opc / 8);
          end
          m_rd = d;
        end
      end
      if (wb_en && wb_addr != 0) mreg[wb_addr] = wb_data;
      if (wb_en) mpend[wb_addr] = 0;
      if (fire && d != 0) mpend[d] = 1;
      tick;
      total++; if (en_ex !== m_en) begin bad++; $display("FAIL rnd_en c=%0d got=%0h exp=%0h", c, en_ex, m_en); end
      if (m_en) begin
        total++;
        if (src1 !== m_src1 || src2 !== m_src2 || imm !== m_imm ||
            cntrl_in !== m_cntrl || rd_addr !== 5'(m_rd)) begin
          bad++;
          $display("FAIL rnd_bundle c=%0d got=%0h/%0h/%0h/%b/%0d exp=%0h/%0h/%0h/%b/%0d",
                   c, src1, src2, imm, cntrl_in, rd_addr,
                   m_src1, m_src2, m_imm, m_cntrl, m_rd);
        end
      end
    end
    instr_valid = 0; stall = 0; wb_en = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_back_to_back;
    test_hazard;
    test_stall;
    test_set_wins;
    test_r0_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
